// File: rtl/multi_cycle_mips_32.sv
// Multi-cycle MIPS-32 core: FSM-sequenced datapath sharing one ALU and one
// unified instruction/data word memory, with retire and halt status outputs.
module multi_cycle_mips_32 #(
  parameter int          MEM_DEPTH = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        instr_retire,
  output logic        halted,
  output logic [31:0] retire_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB_R = 4'd7,
    S_ALU_WB_I = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] regs [32];

  state_t      cur_state;
  state_t      next_state;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  alu_op_t     alu_op;
  alu_op_t     exec_op;
  logic        funct_ok;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        retire_next;

  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       mem_rdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] x,
                                           input logic [31:0] y);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_NOR: r = ~(x | y);
      ALU_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign state    = cur_state;

  // Single memory read port: instruction fetch uses pc, data loads use alu_out.
  assign mem_idx   = (cur_state == S_FETCH) ? pc[ADDR_W+1:2] : alu_out[ADDR_W+1:2];
  assign mem_rdata = mem[mem_idx];

  // Decode the R-type function field into an ALU operation.
  always_comb begin
    funct_ok = 1'b1;
    exec_op  = ALU_ADD;
    case (funct)
      6'h20:   exec_op = ALU_ADD;
      6'h22:   exec_op = ALU_SUB;
      6'h24:   exec_op = ALU_AND;
      6'h25:   exec_op = ALU_OR;
      6'h27:   exec_op = ALU_NOR;
      6'h2A:   exec_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // Shared ALU operand selection per state.
  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (cur_state)
      S_DECODE:   alu_b = {imm_sext[29:0], 2'b00};
      S_MEM_ADDR: begin
        alu_a = a_reg;
        alu_b = imm_sext;
      end
      S_EXEC: begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = exec_op;
      end
      S_BRANCH: begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = ALU_SUB;
      end
      default: alu_op = ALU_ADD;
    endcase
    alu_y = alu_calc(alu_op, alu_a, alu_b);
  end

  // Next-state selection and retire flag for the upcoming cycle.
  always_comb begin
    next_state  = cur_state;
    retire_next = 1'b0;
    case (cur_state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: next_state = S_MEM_ADDR;
          OP_RTYPE:              next_state = S_EXEC;
          OP_BEQ:                next_state = S_BRANCH;
          OP_J:                  next_state = S_JUMP;
          default:               next_state = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          next_state = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          next_state = S_MEM_WR;
        end else begin
          next_state = S_ALU_WB_I;
        end
      end
      S_MEM_RD: next_state = S_MEM_WB;
      S_EXEC: begin
        if (funct_ok) begin
          next_state = S_ALU_WB_R;
        end else begin
          next_state = S_HALT;
        end
      end
      S_MEM_WB, S_MEM_WR, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_HALT;
    endcase
    case (next_state)
      S_MEM_WB, S_MEM_WR, S_ALU_WB_R, S_ALU_WB_I, S_BRANCH, S_JUMP: retire_next = 1'b1;
      default: retire_next = 1'b0;
    endcase
  end

  // Register file write port selection.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (cur_state)
      S_MEM_WB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
      end
      S_ALU_WB_R: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      S_ALU_WB_I: rf_we = 1'b1;
      default:    rf_we = 1'b0;
    endcase
  end

  // FSM state, status outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= 32'd0;
      mdr          <= 32'd0;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      alu_out      <= 32'd0;
      instr_retire <= 1'b0;
      halted       <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      cur_state    <= next_state;
      instr_retire <= retire_next;
      halted       <= halted | (next_state == S_HALT);
      retire_count <= retire_count + {31'd0, instr_retire};
      case (cur_state)
        S_FETCH: begin
          ir <= mem_rdata;
          pc <= alu_y;
        end
        S_DECODE: begin
          a_reg   <= rs_val;
          b_reg   <= rt_val;
          alu_out <= alu_y;
        end
        S_MEM_ADDR: alu_out <= alu_y;
        S_MEM_RD:   mdr <= mem_rdata;
        S_EXEC: begin
          if (funct_ok) begin
            alu_out <= alu_y;
          end
        end
        S_BRANCH: begin
          if (alu_y == 32'd0) begin
            pc <= alu_out;
          end
        end
        S_JUMP:  pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file write; $0 stays zero and reset aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory store; reset aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && (cur_state == S_MEM_WR)) begin
      mem[alu_out[ADDR_W+1:2]] <= b_reg;
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips_32.sv
// Scoreboard bench for multi_cycle_mips_32: directed programs push expected
// retire records; a monitor pops one per instr_retire pulse and checks it.
module tb_multi_cycle_mips_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [3:0]  state;
  logic        instr_retire;
  logic        halted;
  logic [31:0] retire_count;

  multi_cycle_mips_32 dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .state        (state),
    .instr_retire (instr_retire),
    .halted       (halted),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ILLEGAL = 32'hFC000000;

  typedef struct {
    int          lat;
    logic [31:0] npc;
    logic [31:0] rcnt;
    int          kind;   // 0 none, 1 register, 2 memory
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   pend   = 1'b0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int lat, input logic [31:0] npc, input logic [31:0] rcnt,
                      input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.lat = lat; e.npc = npc; e.rcnt = rcnt; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  // Monitor: latency at the retire pulse, architectural effects one cycle later.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      cyc  = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("next_pc", pc, cur.npc);
        chk("retire_count", retire_count, cur.rcnt);
        if (cur.kind == 1) chk($sformatf("reg%0d", cur.idx), dut.regs[cur.idx], cur.val);
        if (cur.kind == 2) chk($sformatf("mem%0d", cur.idx), dut.mem[cur.idx], cur.val);
        pend = 1'b0;
      end
      if (state == 4'd0) cyc = 1;
      else cyc++;
      if (instr_retire) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc, cur.lat);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic begin_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) dut.mem[i] = ILLEGAL;
    for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
  endtask

  task automatic end_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !pend) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    // Reset state, then LW $1,8($0)
    begin_reset();
    dut.mem[0] = 32'h8C010008;
    dut.mem[2] = 32'd17;
    end_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_retire", {31'd0, instr_retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_rcount", retire_count, 32'd0);
    push(5, 32'd4, 32'd1, 1, 1, 32'd17);
    drain("lw", 40);

    // R-type ALU operations
    begin_reset();
    dut.regs[1]  = 32'd22;
    dut.regs[2]  = 32'd12;
    dut.regs[10] = 32'hFFFFFFFF;
    dut.mem[0] = 32'h00221824;  // AND $3
    dut.mem[1] = 32'h00222025;  // OR  $4
    dut.mem[2] = 32'h00222827;  // NOR $5
    dut.mem[3] = 32'h00223022;  // SUB $6
    dut.mem[4] = 32'h0022382A;  // SLT $7,$1,$2
    dut.mem[5] = 32'h0041402A;  // SLT $8,$2,$1
    dut.mem[6] = 32'h00224820;  // ADD $9
    dut.mem[7] = 32'h0141582A;  // SLT $11,$10,$1 (signed)
    end_reset();
    push(4, 32'd4,  32'd1, 1, 3,  32'h4);
    push(4, 32'd8,  32'd2, 1, 4,  32'h1E);
    push(4, 32'd12, 32'd3, 1, 5,  32'hFFFFFFE1);
    push(4, 32'd16, 32'd4, 1, 6,  32'd10);
    push(4, 32'd20, 32'd5, 1, 7,  32'd0);
    push(4, 32'd24, 32'd6, 1, 8,  32'd1);
    push(4, 32'd28, 32'd7, 1, 9,  32'd34);
    push(4, 32'd32, 32'd8, 1, 11, 32'd1);
    drain("rtype", 80);

    // ADDI negative, SW, and a discarded write to $0
    begin_reset();
    dut.mem[0] = 32'h2001FFFD;  // ADDI $1,$0,-3
    dut.mem[1] = 32'hAC010028;  // SW $1,40($0)
    dut.mem[2] = 32'h20000005;  // ADDI $0,$0,5
    end_reset();
    push(4, 32'd4,  32'd1, 1, 1,  32'hFFFFFFFD);
    push(4, 32'd8,  32'd2, 2, 10, 32'hFFFFFFFD);
    push(4, 32'd12, 32'd3, 1, 0,  32'd0);
    drain("addi_sw", 40);

    // J 5 then backward taken BEQ (loops; stopped by the next reset)
    begin_reset();
    dut.mem[0] = 32'h08000005;
    dut.mem[5] = 32'h1000FFFA;
    end_reset();
    push(3, 32'd20, 32'd1, 0, 0, 32'd0);
    push(3, 32'd0,  32'd2, 0, 0, 32'd0);
    push(3, 32'd20, 32'd3, 0, 0, 32'd0);
    push(3, 32'd0,  32'd4, 0, 0, 32'd0);
    drain("j_beq", 40);

    // Not-taken BEQ, then taken forward BEQ
    begin_reset();
    dut.regs[1] = 32'd1;
    dut.mem[0] = 32'h10200005;  // BEQ $1,$0,+5
    dut.mem[1] = 32'h10210002;  // BEQ $1,$1,+2
    end_reset();
    push(3, 32'd4,  32'd1, 0, 0, 32'd0);
    push(3, 32'd16, 32'd2, 0, 0, 32'd0);
    drain("beq", 40);

    // Illegal opcode halts after decode and stays put
    begin_reset();
    end_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_state", {28'd0, state}, 32'd11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("halt_pc", pc, 32'd4);
      chk("halt_rcount", retire_count, 32'd0);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("halt_cleared", {31'd0, halted}, 32'd0);

    // Illegal funct halts from EXEC without writing rd
    begin_reset();
    dut.regs[1] = 32'd22;
    dut.regs[2] = 32'd12;
    dut.regs[3] = 32'h55;
    dut.mem[0]  = 32'h00221800;
    end_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("funct_halt", {31'd0, halted}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("funct_rd_kept", dut.regs[3], 32'h55);
    chk("funct_rcount", retire_count, 32'd0);

    // Reset during MEM_WR aborts the store
    begin_reset();
    dut.regs[1] = 32'h12345678;
    dut.mem[10] = 32'hA5A5A5A5;
    dut.mem[0]  = 32'hAC010028;
    end_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (state == 4'd5) break;
    end
    chk("reach_mem_wr", {28'd0, state}, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_state", {28'd0, state}, 32'd0);
    chk("abort_mem", dut.mem[10], 32'hA5A5A5A5);

    // LW with an address past the top of memory wraps
    begin_reset();
    dut.mem[0] = 32'h8C020408;  // LW $2,1032($0)
    dut.mem[2] = 32'hCAFEF00D;
    end_reset();
    push(5, 32'd4, 32'd1, 1, 2, 32'hCAFEF00D);
    drain("lw_wrap", 40);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
